// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S receive front-end.
package i2s_pkg;

  typedef enum logic [1:0] {
    CH_LEFT   = 2'd0,
    CH_RIGHT  = 2'd1,
    CH_MONO   = 2'd2,
    CH_STEREO = 2'd3
  } ch_mode_e;

  localparam logic CH_TAG_LEFT  = 1'b0;
  localparam logic CH_TAG_RIGHT = 1'b1;

  localparam int unsigned DROP_CNT_W = 8;

endpackage

// File: rtl/i2s_timing_gen.sv
// BCK/LRCK generation from the system clock plus the per-bit sample strobe
// and slot position used by the capture logic.
module i2s_timing_gen #(
  parameter int unsigned CLK_DIV   = 8,
  parameter int unsigned SLOT_BITS = 32,
  localparam int unsigned SLOT_W   = $clog2(SLOT_BITS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en_i,
  output logic              bck_o,
  output logic              lrck_o,
  output logic              strobe_c,
  output logic [SLOT_W-1:0] slot_bit_c,
  output logic              slot_ch_c
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam int unsigned BIT_W = $clog2(2 * SLOT_BITS);

  logic [DIV_W-1:0] div_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic [BIT_W-1:0] bit_nxt_c;
  logic             div_wrap_c;
  logic             bck_fall_c;

  assign div_wrap_c = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign bck_fall_c = div_wrap_c && bck_o;
  assign bit_nxt_c  = (bit_cnt == BIT_W'(2 * SLOT_BITS - 1)) ? '0 : bit_cnt + BIT_W'(1);

  // Sample at the very end of the BCK high phase, just before the fall.
  assign strobe_c   = en_i && bck_o && div_wrap_c;
  assign slot_ch_c  = (bit_cnt >= BIT_W'(SLOT_BITS));
  assign slot_bit_c = slot_ch_c ? SLOT_W'(bit_cnt - BIT_W'(SLOT_BITS)) : SLOT_W'(bit_cnt);

  // lrck_o is updated from the next bit count so it moves with the BCK fall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      bck_o   <= 1'b0;
      lrck_o  <= 1'b0;
    end else if (!en_i) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      bck_o   <= 1'b0;
      lrck_o  <= 1'b0;
    end else begin
      div_cnt <= div_wrap_c ? '0 : div_cnt + DIV_W'(1);
      if (div_wrap_c) bck_o <= !bck_o;
      if (bck_fall_c) begin
        bit_cnt <= bit_nxt_c;
        lrck_o  <= (bit_nxt_c >= BIT_W'(SLOT_BITS));
      end
    end
  end

endmodule

// File: rtl/i2s_frontend.sv
// Single-clock I2S master receiver: Philips-format capture, channel-mode
// selection and a valid/ready output register with overrun accounting.
module i2s_frontend
  import i2s_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 8,
  parameter int unsigned SLOT_BITS = 32,
  parameter int unsigned DATA_BITS = 24,
  parameter int unsigned OUT_WIDTH = 32,
  parameter int unsigned CH_MODE   = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en_i,
  input  logic                  sd_in,
  output logic                  bck_o,
  output logic                  lrck_o,
  output logic [OUT_WIDTH-1:0]  sample_o,
  output logic                  sample_ch_o,
  output logic                  sample_valid_o,
  input  logic                  sample_ready_i,
  output logic                  overrun_o,
  input  logic                  clr_overrun_i,
  output logic [DROP_CNT_W-1:0] drop_cnt_o
);

  localparam int unsigned SLOT_W = $clog2(SLOT_BITS);
  localparam int unsigned PAD_W  = OUT_WIDTH - DATA_BITS;
  localparam ch_mode_e    MODE   = ch_mode_e'(2'(CH_MODE));

  logic                 strobe_c;
  logic [SLOT_W-1:0]    slot_bit_c;
  logic                 slot_ch_c;
  logic                 sd_meta, sd_sync;
  logic [DATA_BITS-2:0] shift_q;
  logic [DATA_BITS-1:0] left_q;
  logic [DATA_BITS-1:0] word_c;
  logic [DATA_BITS:0]   sum_c;
  logic [DATA_BITS-1:0] mono_c;
  logic                 capture_c, done_c;
  logic                 new_vld_c, new_ch_c;
  logic [DATA_BITS-1:0] new_word_c;
  logic                 load_c, drop_c;

  i2s_timing_gen #(
    .CLK_DIV   (CLK_DIV),
    .SLOT_BITS (SLOT_BITS)
  ) u_timing (
    .clk        (clk),
    .reset_n    (reset_n),
    .en_i       (en_i),
    .bck_o      (bck_o),
    .lrck_o     (lrck_o),
    .strobe_c   (strobe_c),
    .slot_bit_c (slot_bit_c),
    .slot_ch_c  (slot_ch_c)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sd_meta <= 1'b0;
      sd_sync <= 1'b0;
    end else begin
      sd_meta <= sd_in;
      sd_sync <= sd_meta;
    end
  end

  // Slot bit 0 is the Philips one-bit delay; data occupies bits 1..DATA_BITS.
  assign word_c    = {shift_q, sd_sync};
  assign capture_c = strobe_c && (slot_bit_c != '0) && (slot_bit_c <= SLOT_W'(DATA_BITS));
  assign done_c    = strobe_c && (slot_bit_c == SLOT_W'(DATA_BITS));
  assign sum_c     = {left_q[DATA_BITS-1], left_q} + {word_c[DATA_BITS-1], word_c};
  assign mono_c    = DATA_BITS'(sum_c >> 1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q <= '0;
      left_q  <= '0;
    end else if (!en_i) begin
      shift_q <= '0;
      left_q  <= '0;
    end else begin
      if (capture_c) shift_q <= word_c[DATA_BITS-2:0];
      if (done_c && (slot_ch_c == CH_TAG_LEFT)) left_q <= word_c;
    end
  end

  always_comb begin
    new_vld_c  = 1'b0;
    new_ch_c   = CH_TAG_LEFT;
    new_word_c = word_c;
    if (done_c) begin
      case (MODE)
        CH_LEFT:   new_vld_c = (slot_ch_c == CH_TAG_LEFT);
        CH_RIGHT: begin
          new_vld_c = (slot_ch_c == CH_TAG_RIGHT);
          new_ch_c  = CH_TAG_RIGHT;
        end
        CH_MONO: begin
          new_vld_c  = (slot_ch_c == CH_TAG_RIGHT);
          new_word_c = mono_c;
        end
        CH_STEREO: begin
          new_vld_c = 1'b1;
          new_ch_c  = slot_ch_c;
        end
        default:   new_vld_c = 1'b0;
      endcase
    end
  end

  // A sample arriving while the held one is refused is dropped, never merged.
  assign load_c = new_vld_c && (!sample_valid_o || sample_ready_i);
  assign drop_c = new_vld_c && sample_valid_o && !sample_ready_i;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sample_o       <= '0;
      sample_ch_o    <= 1'b0;
      sample_valid_o <= 1'b0;
      overrun_o      <= 1'b0;
      drop_cnt_o     <= '0;
    end else begin
      if (load_c) begin
        sample_o       <= OUT_WIDTH'(new_word_c) << PAD_W;
        sample_ch_o    <= new_ch_c;
        sample_valid_o <= 1'b1;
      end else if (sample_valid_o && sample_ready_i) begin
        sample_valid_o <= 1'b0;
      end
      if (clr_overrun_i) begin
        overrun_o  <= drop_c;
        drop_cnt_o <= DROP_CNT_W'(drop_c);
      end else if (drop_c) begin
        overrun_o <= 1'b1;
        if (drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + DROP_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_i2s_frontend.sv
// Directed bench: mono/left vectors on default-rate instances, stereo
// overrun behaviour on a fast small-word instance.
module tb_i2s_frontend;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic en_i = 1'b1;
  logic sd0 = 1'b0, sd3 = 1'b0;
  logic rand_sd = 1'b1;
  logic [23:0] l_word = '0, r_word = '0;
  logic [7:0]  l3 = 8'hC3, r3 = 8'h5A;
  logic ready3 = 1'b0, clr3 = 1'b0;

  logic bck0, lrck0, ch0, v0, ov0; logic [31:0] s0; logic [7:0] d0;
  logic bck2, lrck2, ch2, v2, ov2; logic [31:0] s2; logic [7:0] d2;
  logic bck3, lrck3, ch3, v3, ov3; logic [15:0] s3; logic [7:0] d3;

  int vec_cnt = 0, err_cnt = 0, cyc = 0, t_ref;

  always #5 clk = ~clk;

  i2s_frontend #(.CH_MODE(0)) m0 (
    .clk(clk), .reset_n(reset_n), .en_i(en_i), .sd_in(sd0), .bck_o(bck0), .lrck_o(lrck0),
    .sample_o(s0), .sample_ch_o(ch0), .sample_valid_o(v0), .sample_ready_i(1'b1),
    .overrun_o(ov0), .clr_overrun_i(1'b0), .drop_cnt_o(d0));

  i2s_frontend #(.CH_MODE(2)) m2 (
    .clk(clk), .reset_n(reset_n), .en_i(en_i), .sd_in(sd0), .bck_o(bck2), .lrck_o(lrck2),
    .sample_o(s2), .sample_ch_o(ch2), .sample_valid_o(v2), .sample_ready_i(1'b1),
    .overrun_o(ov2), .clr_overrun_i(1'b0), .drop_cnt_o(d2));

  i2s_frontend #(.CLK_DIV(4), .SLOT_BITS(9), .DATA_BITS(8), .OUT_WIDTH(16), .CH_MODE(3)) m3 (
    .clk(clk), .reset_n(reset_n), .en_i(en_i), .sd_in(sd3), .bck_o(bck3), .lrck_o(lrck3),
    .sample_o(s3), .sample_ch_o(ch3), .sample_valid_o(v3), .sample_ready_i(ready3),
    .overrun_o(ov3), .clr_overrun_i(clr3), .drop_cnt_o(d3));

  always @(posedge clk or negedge reset_n)
    if (!reset_n) cyc <= 0;
    else cyc <= cyc + 1;

  // ADC models: MSB one BCK after the LRCK change, driven after each BCK fall.
  int pos0 = 0, pos3 = 0;
  logic pb0 = 1'b0, pl0 = 1'b0, pb3 = 1'b0, pl3 = 1'b0;
  logic [23:0] wd0; logic [7:0] wd3;
  always @(negedge clk) begin
    if (!reset_n || !en_i) pos0 = 0;
    else if (pb0 && !bck0) pos0 = (lrck0 != pl0) ? 0 : pos0 + 1;
    pb0 = bck0; pl0 = lrck0;
    wd0 = lrck0 ? r_word : l_word;
    if (rand_sd) sd0 = 1'($urandom);
    else if (pos0 >= 1 && pos0 <= 24) sd0 = wd0[5'(24 - pos0)];
    else sd0 = 1'b0;
  end
  always @(negedge clk) begin
    if (!reset_n || !en_i) pos3 = 0;
    else if (pb3 && !bck3) pos3 = (lrck3 != pl3) ? 0 : pos3 + 1;
    pb3 = bck3; pl3 = lrck3;
    wd3 = lrck3 ? r3 : l3;
    if (pos3 >= 1 && pos3 <= 8) sd3 = wd3[3'(8 - pos3)];
    else sd3 = 1'b0;
  end

  // Records the first clock edges seen on m0 after the first reset release.
  int t_bck1 = -1, t_bck2 = -1, t_lr_r = -1, t_lr_f = -1;
  int lr_r_ok = 0, lr_f_ok = 0;
  logic mb = 1'b0, ml = 1'b0;
  always @(negedge clk) begin
    if (reset_n) begin
      if (bck0 && !mb) begin
        if (t_bck1 < 0) t_bck1 = cyc;
        else if (t_bck2 < 0) t_bck2 = cyc;
      end
      if (lrck0 && !ml && t_lr_r < 0) begin t_lr_r = cyc; lr_r_ok = int'(mb && !bck0); end
      if (!lrck0 && ml && t_lr_f < 0) begin t_lr_f = cyc; lr_f_ok = int'(mb && !bck0); end
    end
    mb = bck0; ml = lrck0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      0: return v0;
      1: return v2;
      2: return v3;
      3: return lrck0;
      4: return lrck3;
      default: return logic'(d3 == 8'd255);
    endcase
  endfunction

  task automatic wait_for(input int which, input logic level, input int budget, input string name);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (sig(which) === level) return;
    end
    vec_cnt++;
    err_cnt++;
    $display("FAIL %s: timeout after %0d cycles", name, budget);
  endtask

  typedef struct {
    logic [23:0] l, r;
    logic [31:0] exp_m0, exp_m2;
  } vec_t;
  vec_t tbl[7];
  int viol;

  initial begin
    tbl[0] = '{24'h123456, 24'hABCDEF, 32'h12345600, 32'hDF012200};
    tbl[1] = '{24'h7FFFFF, 24'h000001, 32'h7FFFFF00, 32'h40000000};
    tbl[2] = '{24'h800000, 24'h800000, 32'h80000000, 32'h80000000};
    tbl[3] = '{24'hFFFFFF, 24'h000000, 32'hFFFFFF00, 32'hFFFFFF00};
    tbl[4] = '{24'h000000, 24'hFFFFFF, 32'h00000000, 32'hFFFFFF00};
    tbl[5] = '{24'hA5A5A5, 24'h5A5A5A, 32'hA5A5A500, 32'hFFFFFF00};
    tbl[6] = '{24'h400000, 24'h400000, 32'h40000000, 32'h40000000};

    // Reset with enable high and noisy data.
    repeat (20) @(negedge clk);
    check("rst_bck", 32'(bck0), 0);
    check("rst_lrck", 32'(lrck0), 0);
    check("rst_sample", s0, 0);
    check("rst_ch", 32'(ch0), 0);
    check("rst_valid", 32'(v0), 0);
    check("rst_overrun", 32'(ov0), 0);
    check("rst_drop", 32'(d0), 0);
    check("rst_mono_sample", s2, 0);
    rand_sd = 1'b0;
    l_word = tbl[0].l; r_word = tbl[0].r;
    reset_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      wait_for(0, 1'b1, 1100, "m0_valid_wait");
      if (i == 0) check("m0_first_latency", 32'(cyc), 400);
      else check("m0_period", 32'(cyc - t_ref), 1024);
      t_ref = cyc;
      check("m0_sample", s0, tbl[i].exp_m0);
      check("m0_ch", 32'(ch0), 0);
      wait_for(1, 1'b1, 600, "m2_valid_wait");
      check("m2_sample", s2, tbl[i].exp_m2);
      check("m2_ch", 32'(ch2), 0);
      if (i < 6) begin l_word = tbl[i+1].l; r_word = tbl[i+1].r; end
    end

    check("bck_first_rise", 32'(t_bck1), 8);
    check("bck_period", 32'(t_bck2 - t_bck1), 16);
    check("lrck_rise", 32'(t_lr_r), 512);
    check("lrck_fall", 32'(t_lr_f), 1024);
    check("lrck_rise_on_bck_fall", 32'(lr_r_ok), 1);
    check("lrck_fall_on_bck_fall", 32'(lr_f_ok), 1);

    // Drop enable mid-left-slot; new data is only visible after re-enable.
    wait_for(3, 1'b0, 1100, "lrck_fall_wait");
    repeat (200) @(negedge clk);
    en_i = 1'b0;
    viol = 0;
    l_word = 24'h2468AC; r_word = 24'h13579B;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bck0 || lrck0 || v0 || v2) viol++;
    end
    check("disabled_quiet", 32'(viol), 0);
    en_i = 1'b1;
    t_ref = cyc;
    wait_for(0, 1'b1, 1100, "m0_after_en_wait");
    check("en_latency", 32'(cyc - t_ref), 400);
    check("en_m0_sample", s0, 32'h2468AC00);
    wait_for(1, 1'b1, 600, "m2_after_en_wait");
    check("en_m2_sample", s2, 32'h1BE02300);

    // Reset in the middle of a right slot in mono mode.
    l_word = 24'h7FFFFF; r_word = 24'h7FFFFF;
    wait_for(0, 1'b1, 1100, "m0_pre_reset_wait");
    repeat (300) @(negedge clk);
    check("pre_reset_lrck", 32'(lrck2), 1);
    reset_n = 1'b0;
    #1;
    check("async_rst_sample", s2, 0);
    check("async_rst_lrck", 32'(lrck2), 0);
    check("async_rst_bck", 32'(bck2), 0);
    check("async_rst_valid", 32'(v2), 0);
    repeat (5) @(negedge clk);
    l_word = 24'h000010; r_word = 24'h000020;
    reset_n = 1'b1;
    wait_for(1, 1'b1, 1100, "m2_after_rst_wait");
    check("post_rst_m2_latency", 32'(cyc), 912);
    check("post_rst_m2_sample", s2, 32'h00001800);

    // Stereo instance with ready held low: hold, drop, saturate, clear.
    @(negedge clk);
    reset_n = 1'b0;
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    wait_for(2, 1'b1, 200, "m3_first_wait");
    check("m3_first_latency", 32'(cyc), 72);
    check("m3_first_sample", 32'(s3), 32'h0000C300);
    check("m3_first_ch", 32'(ch3), 0);
    wait_for(5, 1'b1, 22000, "m3_saturate_wait");
    check("m3_held_sample", 32'(s3), 32'h0000C300);
    check("m3_held_ch", 32'(ch3), 0);
    check("m3_held_valid", 32'(v3), 1);
    check("m3_overrun", 32'(ov3), 1);
    repeat (300) @(negedge clk);
    check("m3_drop_saturated", 32'(d3), 255);
    wait_for(4, 1'b1, 200, "m3_lrck_rise_wait");
    clr3 = 1'b1;
    @(negedge clk);
    clr3 = 1'b0;
    check("m3_clr_overrun", 32'(ov3), 0);
    check("m3_clr_drop", 32'(d3), 0);
    wait_for(4, 1'b0, 200, "m3_lrck_low_wait");
    wait_for(4, 1'b1, 200, "m3_lrck_rise_wait2");
    repeat (71) @(negedge clk);
    clr3 = 1'b1;
    @(negedge clk);
    clr3 = 1'b0;
    check("m3_clr_with_drop_cnt", 32'(d3), 1);
    check("m3_clr_with_drop_ov", 32'(ov3), 1);
    r3 = 8'h96;
    wait_for(4, 1'b0, 200, "m3_lrck_low_wait2");
    wait_for(4, 1'b1, 200, "m3_lrck_rise_wait3");
    repeat (71) @(negedge clk);
    ready3 = 1'b1;
    @(negedge clk);
    ready3 = 1'b0;
    check("m3_ready_valid", 32'(v3), 1);
    check("m3_ready_sample", 32'(s3), 32'h00009600);
    check("m3_ready_ch", 32'(ch3), 1);
    check("m3_ready_no_drop", 32'(d3), 2);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/i2s_frontend.md
Name: i2s_frontend

Overview:
- Single-clock I2S master receive front-end: generates BCK/LRCK from the system clock and deserialises the ADC's serial data.
- Produces width-converted samples with a valid/ready handshake to the FFT sample input.
- Replaces the dual-clock-domain receiver and change-detect valid path with one clock domain and explicit strobes.
- Adds selectable channel mode (left, right, mono average, stereo interleaved) and overrun reporting.

Parameters:
- CLK_DIV, 8: clk cycles per BCK half-period; must be ≥4. Default gives 3 MHz BCK from 48 MHz.
- SLOT_BITS, 32: BCK cycles per channel slot; must be ≥ DATA_BITS+1.
- DATA_BITS, 24: significant two's-complement bits per channel word.
- OUT_WIDTH, 32: sample_o width; must be ≥ DATA_BITS.
- CH_MODE, 0: 0 = left only, 1 = right only, 2 = mono (L+R)/2, 3 = stereo interleaved.

Ports:
- clk  in  1  system clock (48 MHz HSOSC)
- reset_n  in  1  asynchronous active-low reset
- en_i  in  1  run enable
- sd_in  in  1  I2S serial data from ADC
- bck_o  out  1  generated bit clock
- lrck_o  out  1  generated word select; 0 = left slot
- sample_o  out  OUT_WIDTH  output sample
- sample_ch_o  out  1  channel tag: 0 = left, 1 = right (mono mode tags 0)
- sample_valid_o  out  1  sample available
- sample_ready_i  in  1  consumer accepts sample
- overrun_o  out  1  sticky flag: a sample was dropped
- clr_overrun_i  in  1  synchronous clear of overrun_o and drop_cnt_o
- drop_cnt_o  out  8  saturating dropped-sample count

Behaviour:
- Reset: all outputs and state are 0 (bck_o, lrck_o, sample_o, sample_ch_o, sample_valid_o, overrun_o, drop_cnt_o, counters, shift register).
- Timing:
  - div_cnt counts 0..CLK_DIV-1; bck_o toggles on wrap.
  - bit_cnt (0..2*SLOT_BITS-1) advances on each bck_o falling toggle.
  - lrck_o = (bit_cnt ≥ SLOT_BITS), so lrck_o changes coincident with the bck_o falling edge.
  - Frame length = 4*CLK_DIV*SLOT_BITS clk (1024 by default).
- sd_in passes through a 2-flop synchroniser.
- Sample strobe: the last clk cycle of each bck_o high phase (bck_o==1 and div_cnt==CLK_DIV-1).
- Capture (Philips one-bit delay):
  - slot_bit = bit_cnt mod SLOT_BITS.
  - On a sample strobe with slot_bit in 1..DATA_BITS, the synchronised sd_in is shifted in MSB-first.
  - All other slot bits are ignored.
  - A word completes on the strobe where slot_bit==DATA_BITS.
- Conversion: out = {word, (OUT_WIDTH-DATA_BITS) zeros}, i.e. left-justified with the sign preserved.
- Mode emission:
  - Mode 0 emits on left-word completion; mode 1 on right-word completion; mode 3 emits both, tagged by channel.
  - Mode 2: left word is held; on right-word completion emit (sext(L)+sext(R))>>>1 computed at DATA_BITS+1 bits, truncated to DATA_BITS.
- Latency: sample_valid_o rises on the clk edge ending the completing strobe cycle (1 clk).
- Handshake:
  - The output holding register keeps sample_o/sample_ch_o stable while sample_valid_o && !sample_ready_i.
  - valid && ready deasserts valid next cycle unless a new sample arrives in the same cycle. In that case the register loads the new sample, valid stays 1, and no overrun is recorded.
  - A new sample while valid && !ready: the new sample is dropped, the held one is kept, overrun_o←1, and drop_cnt_o increments, saturating at 255.
  - clr_overrun_i zeroes both; if a drop occurs in the same cycle, the clear wins and the count becomes 1.
- Enable:
  - en_i low: div_cnt/bit_cnt/shift register are cleared; bck_o and lrck_o are held 0; partial words and the mono-held left word are discarded.
  - The output holding register and handshake keep operating while disabled.
  - en_i rising starts at bit_cnt=0 (left slot); the first valid sample comes from the first complete slot.
- Reset mid-frame: immediate return to reset state; no partial sample is ever emitted.

Decomposition:
- Package i2s_pkg: ch_mode_e enum (CH_LEFT=0, CH_RIGHT=1, CH_MONO=2, CH_STEREO=3), CH_TAG_LEFT/RIGHT constants, DROP_CNT_W=8.
- Sub-module i2s_timing_gen: div_cnt, bit_cnt, bck_o, lrck_o generation; outputs sample strobe and slot_bit/channel.
- Capture, conversion and handshake stay in i2s_frontend.

Test Plan:
- Reset: hold reset_n=0 with en_i=1 and random sd_in → every output is 0. Release reset → first bck_o rise at clk 8, bck period 16 clk, lrck_o period 1024 clk, lrck_o edges coincide with bck_o falls.
- CH_MODE=0: BFM drives L=24'h123456, R=24'hABCDEF, sample_ready_i=1 → sample_o=32'h12345600, sample_ch_o=0, exactly one valid pulse per 1024 clk, valid 1 clk after the 25th left-slot strobe.
- CH_MODE=2: L=24'h7FFFFF, R=24'h000001 → 32'h40000000. L=R=24'h800000 → 32'h80000000. L=24'hFFFFFF, R=24'h000000 → 32'hFFFFFF00.
- CH_MODE=3 with ready held 0:
  - first left sample holds stable; later samples are dropped; overrun_o=1; drop_cnt_o counts to 255 and stays.
  - clr_overrun_i pulse → both 0.
  - Raise ready in the cycle a new sample arrives → new sample loaded, valid stays 1, no drop.
- en_i dropped mid-left-slot for 100 clk, then raised → no sample emitted from the partial frame; bck_o/lrck_o are 0 while disabled; the next sample equals the first full frame's data.
- reset_n asserted mid-right-slot in CH_MODE=2 → all outputs 0 immediately. After release the first mono sample uses only post-reset L and R words.
